// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state enum, opcodes
// and the ALU/PC mux select codes driven onto the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_ADDI_EX,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, addi,
// beq, j) with a retired-instruction counter and a sticky illegal flag.
module mips_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic [1:0]       PCSrc,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  import mips_ctrl_pkg::*;

  state_t state, state_next;
  logic   retire;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Counter wraps silently at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst)        retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  assign instr_done = retire;
  assign illegal    = (state == S_ILLEGAL);

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = SRCB_REG;
    AluOp      = ALUOP_ADD;
    PCSrc      = PCSRC_ALU;

    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        AluSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPE_EX;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_RTYPE_EX: begin
        AluSrcA    = 1'b1;
        AluOp      = ALUOP_FUNCT;
        state_next = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        MemToReg   = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDI_EX: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_IMM;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA    = 1'b1;
        AluOp      = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCWrite    = zero;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_FETCH;
    endcase

    // Reset aborts the current instruction: no enables, selects or retire.
    if (!rst) begin
      retire   = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      AluSrcA  = 1'b0;
      AluSrcB  = SRCB_REG;
      AluOp    = ALUOP_ADD;
      PCSrc    = PCSRC_ALU;
    end
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm (CNT_W=4): per-cycle expected outputs and
// retire count go through a scoreboard queue and are checked at negedge.
module tb_mips_ctrl_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string      tag;
    ctl_t       ctl;
    logic [3:0] ret;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
  logic       IorD, RegDst, MemToReg, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSrc;
  logic       instr_done, illegal;
  logic [3:0] retired;
  ctl_t       obs;

  exp_t       sb[$];
  logic [3:0] exp_ret = '0;
  int         n_cmp = 0;
  int         n_fail = 0;

  mips_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst),
    .MemToReg(MemToReg), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSrc(PCSrc), .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );

  assign obs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst,
                MemToReg, AluSrcA, AluSrcB, AluOp, PCSrc, instr_done, illegal};

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Expected control words, one per state, written from the state table.
  function automatic ctl_t c_fetch(logic rdy);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy;
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.alu_src_b = 2'b11;
    return c;
  endfunction
  function automatic ctl_t c_memadr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_memrd();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwr(logic rdy);
    ctl_t c = '0;
    c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = rdy;
    return c;
  endfunction
  function automatic ctl_t c_rtype_ex();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_rtype_wb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_addi_ex();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_addi_wb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_branch(logic z);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write = z;
    c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_illegal();
    ctl_t c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, check at negedge.
  task automatic step(string tag, logic [5:0] op, logic z, logic rdy, logic r, ctl_t c);
    exp_t e;
    opcode = op; zero = z; mem_ready = rdy; rst = r;
    sb.push_back('{tag: tag, ctl: c, ret: exp_ret});
    if (!r)                exp_ret = '0;
    else if (c.instr_done) exp_ret = exp_ret + 4'd1;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%h expected=%h", e.tag, obs, e.ctl);
    end
    n_cmp++;
    assert (retired === e.ret) else begin
      n_fail++;
      $error("FAIL %s retired observed=%0d expected=%0d", e.tag, retired, e.ret);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: outputs forced to zero even with mem_ready high.
    step("reset", LW, 1'b1, 1'b1, 1'b0, '0);

    // lw, 5 cycles, with one fetch stall first.
    step("lw_fetch_wait", LW, 0, 0, 1, c_fetch(1'b0));
    step("lw_fetch",      LW, 0, 1, 1, c_fetch(1'b1));
    step("lw_decode",     LW, 0, 1, 1, c_decode());
    step("lw_memadr",     LW, 0, 1, 1, c_memadr());
    step("lw_memrd",      LW, 0, 1, 1, c_memrd());
    step("lw_memwb",      LW, 0, 1, 1, c_memwb());

    // sw with mem_ready low 3 cycles in MEMWR.
    step("sw_fetch",  SW, 0, 1, 1, c_fetch(1'b1));
    step("sw_decode", SW, 0, 0, 1, c_decode());
    step("sw_memadr", SW, 0, 0, 1, c_memadr());
    for (int i = 0; i < 3; i++) step("sw_memwr_wait", SW, 0, 0, 1, c_memwr(1'b0));
    step("sw_memwr_rdy", SW, 0, 1, 1, c_memwr(1'b1));

    // R-type and addi.
    step("rt_fetch",  RT, 0, 1, 1, c_fetch(1'b1));
    step("rt_decode", RT, 0, 1, 1, c_decode());
    step("rt_ex",     RT, 0, 1, 1, c_rtype_ex());
    step("rt_wb",     RT, 0, 1, 1, c_rtype_wb());
    step("addi_fetch",  ADDI, 0, 1, 1, c_fetch(1'b1));
    step("addi_decode", ADDI, 0, 1, 1, c_decode());
    step("addi_ex",     ADDI, 0, 1, 1, c_addi_ex());
    step("addi_wb",     ADDI, 0, 1, 1, c_addi_wb());

    // beq taken, then not taken.
    step("beq1_fetch",  BEQ, 1, 1, 1, c_fetch(1'b1));
    step("beq1_decode", BEQ, 1, 1, 1, c_decode());
    step("beq1_branch", BEQ, 1, 1, 1, c_branch(1'b1));
    step("beq0_fetch",  BEQ, 0, 1, 1, c_fetch(1'b1));
    step("beq0_decode", BEQ, 0, 1, 1, c_decode());
    step("beq0_branch", BEQ, 0, 1, 1, c_branch(1'b0));

    // Unknown opcode: ILLEGAL on cycle 3, held with retired unchanged.
    step("bad_fetch",  BAD, 0, 1, 1, c_fetch(1'b1));
    step("bad_decode", BAD, 0, 1, 1, c_decode());
    for (int i = 0; i < 10; i++) step("bad_hold", BAD, 0, 1, 1, c_illegal());
    // The flag is decoded from state and only clears on the reset edge.
    step("bad_reset", BAD, 0, 1, 0, c_illegal());
    step("bad_after", SW, 0, 1, 1, c_fetch(1'b1));

    // Reset in MEMWR with mem_ready high aborts the store without a retire.
    step("abort_decode", SW, 0, 1, 1, c_decode());
    step("abort_memadr", SW, 0, 1, 1, c_memadr());
    step("abort_memwr",  SW, 0, 1, 0, '0);
    step("abort_fetch",  SW, 0, 1, 1, c_fetch(1'b1));
    step("abort_decode2", J, 0, 1, 1, c_decode());
    step("abort_jump",    J, 0, 1, 1, c_jump());

    // 16 jumps: counter runs 1 -> 15 -> 0 -> 1 (starting from 1 above).
    for (int i = 0; i < 16; i++) begin
      step("j_fetch",  J, 0, 1, 1, c_fetch(1'b1));
      step("j_decode", J, 0, 1, 1, c_decode());
      step("j_jump",   J, 0, 1, 1, c_jump());
    end
    step("j_final_fetch", J, 0, 0, 1, c_fetch(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag, same cycle.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemRead, MemWrite  output  1 each  write/read enables.
REQ-008 IorD, RegDst, MemToReg, AluSrcA  output  1 each  datapath mux selects; MemToReg=1 selects the ALU result, 0 selects memory data.
REQ-009 AluSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 AluOp  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-011 PCSrc  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-012 instr_done  output  1  one-cycle pulse on instruction retire.
REQ-013 illegal  output  1  sticky unknown-opcode flag.
REQ-014 retired  output  CNT_W  retired-instruction count.

Function
REQ-015 Moore FSM; outputs decode from the registered state only (plus zero and mem_ready where stated); unlisted outputs are 0.
REQ-016 FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-017 DECODE: AluSrcA=0, AluSrcB=11, AluOp=00; next: 100011/101011 -> MEMADR, 000000 -> RTYPE_EX, 001000 -> ADDI_EX, 000100 -> BRANCH, 000010 -> JUMP, otherwise ILLEGAL.
REQ-018 MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00; lw -> MEMRD, sw -> MEMWR (opcode held stable by IR).
REQ-019 MEMRD: MemRead=1, IorD=1; wait for mem_ready, then MEMWB.
REQ-020 MEMWB: RegWrite=1, RegDst=0, MemToReg=0; -> FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; wait for mem_ready, then FETCH.
REQ-022 RTYPE_EX: AluSrcA=1, AluSrcB=00, AluOp=10 -> RTYPE_WB; RTYPE_WB: RegWrite=1, RegDst=1, MemToReg=1 -> FETCH.
REQ-023 ADDI_EX: AluSrcA=1, AluSrcB=10, AluOp=00 -> ADDI_WB; ADDI_WB: RegWrite=1, RegDst=0, MemToReg=1 -> FETCH.
REQ-024 BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSrc=01, PCWrite=zero -> FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-026 ILLEGAL: all enables 0, illegal=1; state held until reset.
REQ-027 Retire = transition into FETCH from MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BRANCH or JUMP; that cycle instr_done=1 and retired increments by 1.
REQ-028 retired wraps from 2^CNT_W-1 to 0 with no flag.
REQ-029 mem_ready outside FETCH/MEMRD/MEMWR is ignored.
REQ-030 Latencies: lw 5 cycles, sw/R-type/addi 4, beq/j 3 (with mem_ready=1 throughout).

Reset
REQ-031 On a rising edge with rst=0: state=FETCH, retired=0, illegal=0.
REQ-032 While rst=0 all enables (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) and instr_done are forced to 0, and selects are forced to 0.
REQ-033 Reset mid-instruction aborts it without a retire count; the first cycle with rst=1 is in FETCH.

Structure
REQ-034 Package mips_ctrl_pkg holds the state enum, opcode constants, and the AluOp, AluSrcB and PCSrc encodings.
REQ-035 Single module, no sub-module: one state register, one next-state/output decoder, one counter.

Verification
REQ-036 lw (100011) with mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 in cycle 5 only; retired 0->1.
REQ-037 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles; one retire only after ready.
REQ-038 beq with zero=1, then beq with zero=0 -> PCWrite=1 with PCSrc=01 in the first BRANCH cycle, 0 in the second; both retire.
REQ-039 opcode 111111 -> ILLEGAL on cycle 3, illegal=1 held for 10 cycles, retired unchanged; rst=0 clears it.
REQ-040 rst=0 asserted in MEMWR with mem_ready=1 -> MemWrite=0, no instr_done, next state FETCH, retired=0.
REQ-041 CNT_W=4: 16 consecutive j (000010) -> retired wraps 15->0.
